// File: rtl/bru_pkg.sv
// Shared definitions for the branch resolve unit: opcode modes, default field widths and
// the output queue entry layout.
package bru_pkg;

  localparam int unsigned BRU_ADDR_W = 16;
  localparam int unsigned BRU_ROB_W  = 5;
  localparam int unsigned BRU_ARCH_W = 8;
  localparam int unsigned BRU_PHYS_W = 10;

  localparam logic [1:0] BRU_MODE_COND     = 2'b00;
  localparam logic [1:0] BRU_MODE_UNCOND   = 2'b01;
  localparam logic [1:0] BRU_MODE_INDIRECT = 2'b10;
  localparam logic [1:0] BRU_MODE_ILLEGAL  = 2'b11;

  typedef struct packed {
    logic [BRU_ADDR_W-1:0] addr;
    logic                  taken;
    logic                  mispredict;
    logic                  illegal;
    logic [BRU_ROB_W-1:0]  rob_tag;
    logic [BRU_ARCH_W-1:0] arch;
    logic [BRU_PHYS_W-1:0] phys;
  } bru_entry_t;

endpackage

// File: rtl/bru_fifo.sv
// Generic synchronous FIFO with flush. Pointers carry one extra wrap bit so full and empty
// are told apart without a separate counter. DEPTH must be a power of two, >= 2.
module bru_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full, empty, push_en, pop_en;

  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // Ready depends only on registered state: a pop this cycle does not free a slot for a push.
  assign push_ready = ~full;
  assign pop_valid  = ~empty;
  assign push_en    = push_valid & ~full & ~flush;
  assign pop_en     = ~empty & pop_ready;
  assign pop_data   = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer values; flush overrides any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // Pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; stale contents are never visible because the reader gates on valid.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch/jump resolution unit: computes the next PC, taken and mispredict flags at issue and
// queues the result toward ROB/redirect. Optional BRU_STATS_EN adds resolve/mispredict counters.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int unsigned ADDR_W = BRU_ADDR_W,
  parameter int unsigned OFF_W  = 8,
  parameter int unsigned IMM_W  = 4,
  parameter int unsigned FLAG_W = 8,
  parameter int unsigned ROB_W  = BRU_ROB_W,
  parameter int unsigned ARCH_W = BRU_ARCH_W,
  parameter int unsigned PHYS_W = BRU_PHYS_W,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [3:0]        opcode,
  input  logic [ADDR_W-1:0] reg_base_val,
  input  logic [FLAG_W-1:0] flag_vals,
  input  logic [OFF_W-1:0]  offset,
  input  logic [IMM_W-1:0]  immediate,
  input  logic [ADDR_W-1:0] pred_addr,
  input  logic [ROB_W-1:0]  rob_tag,
  input  logic [ARCH_W-1:0] arch_dest_regs,
  input  logic [PHYS_W-1:0] phys_dest_regs,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [ADDR_W-1:0] result_addr,
  output logic              result_taken,
  output logic              result_mispredict,
  output logic              result_illegal,
  output logic [ROB_W-1:0]  result_rob_tag,
  output logic [ARCH_W-1:0] arch_dest_regs_out,
  output logic [PHYS_W-1:0] phys_dest_regs_out,
  output logic              result_valid,
  input  logic              result_ready
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]       stat_resolved,
  output logic [31:0]       stat_mispredict
`endif
);

  localparam int unsigned FIDX_W = $clog2(FLAG_W);
  localparam int unsigned EW     = $bits(bru_entry_t);

  // The queue entry layout is fixed by the package; reject mismatched overrides early.
  if (ADDR_W != BRU_ADDR_W || ROB_W != BRU_ROB_W || ARCH_W != BRU_ARCH_W ||
      PHYS_W != BRU_PHYS_W) begin : gen_width_check
    $error("branch_resolve_unit: widths must match bru_pkg entry layout");
  end

  bru_entry_t       entry_in, head;
  logic [EW-1:0]    head_raw;
  logic [ADDR_W-1:0] off_sext, imm_zext, base_inc;
  logic             flag_bit, pop;
  logic             unused_opcode;

  assign unused_opcode = ^opcode[3:2];
  assign off_sext = {{(ADDR_W-OFF_W){offset[OFF_W-1]}}, offset};
  assign imm_zext = {{(ADDR_W-IMM_W){1'b0}}, immediate};
  assign base_inc = reg_base_val + ADDR_W'(1);
  assign flag_bit = flag_vals[immediate[FIDX_W-1:0]];

  // Resolve target and flags for the incoming branch; mispredict is fixed at push time.
  always_comb begin
    entry_in         = '0;
    entry_in.rob_tag = rob_tag;
    entry_in.arch    = arch_dest_regs;
    entry_in.phys    = phys_dest_regs;
    unique case (opcode[1:0])
      BRU_MODE_COND: begin
        // Top immediate bit is polarity: 0 branches on flag set, 1 on flag clear.
        entry_in.taken = (flag_bit == ~immediate[IMM_W-1]);
        entry_in.addr  = entry_in.taken ? reg_base_val + off_sext : base_inc;
      end
      BRU_MODE_UNCOND: begin
        entry_in.taken = 1'b1;
        entry_in.addr  = reg_base_val + imm_zext;
      end
      BRU_MODE_INDIRECT: begin
        entry_in.taken = 1'b1;
        entry_in.addr  = reg_base_val;
      end
      default: begin
        entry_in.taken   = 1'b0;
        entry_in.addr    = base_inc;
        entry_in.illegal = 1'b1;
      end
    endcase
    entry_in.mispredict = (entry_in.addr != pred_addr);
  end

  bru_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push_valid (instr_valid),
    .push_ready (instr_ready),
    .push_data  (entry_in),
    .pop_valid  (result_valid),
    .pop_ready  (result_ready),
    .pop_data   (head_raw)
  );

  assign head = bru_entry_t'(head_raw);
  assign pop  = result_valid & result_ready;

  // Zero-gate every data output while the queue head is empty.
  always_comb begin
    result_addr        = '0;
    result_taken       = 1'b0;
    result_mispredict  = 1'b0;
    result_illegal     = 1'b0;
    result_rob_tag     = '0;
    arch_dest_regs_out = '0;
    phys_dest_regs_out = '0;
    if (result_valid) begin
      result_addr        = head.addr;
      result_taken       = head.taken;
      result_mispredict  = head.mispredict;
      result_illegal     = head.illegal;
      result_rob_tag     = head.rob_tag;
      arch_dest_regs_out = head.arch;
      phys_dest_regs_out = head.phys;
    end
  end

`ifdef BRU_STATS_EN
  logic [31:0] stat_resolved_q, stat_mispredict_q;

  // Saturating pop counters; flush leaves them alone, only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_resolved_q   <= '0;
      stat_mispredict_q <= '0;
    end else if (pop) begin
      if (stat_resolved_q != '1) stat_resolved_q <= stat_resolved_q + 32'd1;
      if (head.mispredict && stat_mispredict_q != '1) begin
        stat_mispredict_q <= stat_mispredict_q + 32'd1;
      end
    end
  end

  assign stat_resolved   = stat_resolved_q;
  assign stat_mispredict = stat_mispredict_q;
`else
  logic unused_pop;
  assign unused_pop = pop;
`endif

endmodule
